ds_box_pow2: RTL



---
 rtl/ds_box_pow2.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ds_box_pow2.sv
// Box-filter downscaler: averages F x F blocks (F = 2^m, m latched per frame) in a single raster pass.
// Latency: the pixel that completes a block yields o_pixel_valid 2 cycles later (read/add, output register).
// No backpressure: one pixel per cycle max; trailing partial blocks and rows are discarded.
module ds_box_pow2 #(
  parameter int BPP      = 10,
  parameter int CAMSIZEX = 640,
  parameter int MAXLOG   = 3,
  parameter int MW       = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_frame_valid,
  input  logic           i_line_valid,
  input  logic [BPP-1:0] i_pixel,
  input  logic           i_pixel_valid,
  input  logic [MW-1:0]  mode,
  output logic           o_frame_valid,
  output logic           o_line_valid,
  output logic [BPP-1:0] o_pixel,
  output logic           o_pixel_valid,
  output logic           o_mode_err,
  output logic           o_ovf
);

  localparam int HW  = BPP + MAXLOG;
  localparam int VW  = BPP + 2*MAXLOG;
  localparam int CW  = $clog2(CAMSIZEX + 1);
  localparam int LBN = CAMSIZEX / 2;
  localparam int IW  = $clog2(LBN);

  logic              fv_d, lv_d, idle_seen, in_frame;
  logic [MW-1:0]     m_active;
  logic [CW-1:0]     hcnt;
  logic [HW-1:0]     hacc;
  logic [MAXLOG-1:0] rcnt;
  logic [VW-1:0]     lbuf [LBN];

  logic              s1_vld, lv_p1, fv_p1;
  logic [VW-1:0]     s1_total;
  logic [MW-1:0]     s1_m;

  logic              frame_rise, frame_fall, line_rise, line_fall, active;
  logic [MW-1:0]     m_clip, m_cur;
  logic [MAXLOG-1:0] fmask, rcnt_eff;
  logic [CW-1:0]     hcnt_eff;
  logic [HW-1:0]     hacc_eff, hsum;
  logic              pix_in, over, accept, blk_done, last_row;
  logic [IW-1:0]     idx_i;
  logic [VW-1:0]     lb_rd, total;
  logic [VW:0]       half, rnd, shifted;

  // A rising frame edge only counts once the frame has been seen low since reset,
  // so a reset released mid-frame waits for the next real frame start.
  assign frame_rise = i_frame_valid & ~fv_d & idle_seen;
  assign frame_fall = ~i_frame_valid & fv_d;
  assign line_rise  = i_line_valid & ~lv_d;
  assign line_fall  = ~i_line_valid & lv_d;
  assign active     = frame_rise | in_frame;

  assign m_clip = (mode > MW'(MAXLOG)) ? MW'(MAXLOG) : mode;
  assign m_cur  = frame_rise ? m_clip : m_active;
  assign fmask  = MAXLOG'((32'd1 << m_cur) - 32'd1);

  // Edge-cycle views so a pixel arriving on the very first cycle of a line/frame sees cleared state.
  assign hcnt_eff = line_rise ? '0 : hcnt;
  assign hacc_eff = line_rise ? '0 : hacc;
  assign rcnt_eff = frame_rise ? '0 : rcnt;

  assign pix_in   = active & i_frame_valid & i_line_valid & i_pixel_valid;
  assign over     = hcnt_eff >= CW'(CAMSIZEX);
  assign accept   = pix_in & ~over;
  assign blk_done = accept & ((hcnt_eff[MAXLOG-1:0] & fmask) == fmask);
  assign last_row = (rcnt_eff == fmask);
  assign hsum     = hacc_eff + HW'(i_pixel);
  assign idx_i    = IW'(hcnt_eff >> m_cur);
  // m=0 bypasses the line buffer entirely; its column index may exceed the buffer.
  assign lb_rd    = (m_cur == '0) ? '0 : lbuf[idx_i];
  assign total    = lb_rd + VW'(hsum);

  // Round half up, then divide by F*F.
  assign half    = ((VW+1)'(1) << {s1_m, 1'b0}) >> 1;
  assign rnd     = {1'b0, s1_total} + half;
  assign shifted = rnd >> {s1_m, 1'b0};

  // Column line buffer: first row of a group overwrites, middle rows accumulate.
  always_ff @(posedge clk) begin
    if (blk_done && !last_row)
      lbuf[idx_i] <= (rcnt_eff == '0) ? VW'(hsum) : total;
  end

  // Frame/line edge tracking, mode latch, counters, accumulators and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_d       <= 1'b0;
      lv_d       <= 1'b0;
      idle_seen  <= 1'b0;
      in_frame   <= 1'b0;
      m_active   <= '0;
      hcnt       <= '0;
      hacc       <= '0;
      rcnt       <= '0;
      o_mode_err <= 1'b0;
      o_ovf      <= 1'b0;
    end else begin
      fv_d      <= i_frame_valid;
      lv_d      <= i_line_valid;
      idle_seen <= idle_seen | ~i_frame_valid;
      if (frame_rise) begin
        m_active <= m_clip;
        in_frame <= 1'b1;
        if (mode > MW'(MAXLOG)) o_mode_err <= 1'b1;
      end else if (frame_fall) begin
        in_frame <= 1'b0;
      end
      if (pix_in && over) o_ovf <= 1'b1;
      if (frame_fall) begin
        hcnt <= '0;
        hacc <= '0;
        rcnt <= '0;
      end else begin
        if (accept) begin
          hcnt <= hcnt_eff + 1'b1;
          hacc <= blk_done ? '0 : hsum;
        end else if (line_rise) begin
          hcnt <= '0;
          hacc <= '0;
        end
        if (frame_rise)
          rcnt <= '0;
        else if (active && line_fall)
          rcnt <= (rcnt == fmask) ? '0 : rcnt + 1'b1;
      end
    end
  end

  // Two-stage output pipe: stage 1 holds the block total, stage 2 the rounded pixel and envelopes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld        <= 1'b0;
      s1_total      <= '0;
      s1_m          <= '0;
      lv_p1         <= 1'b0;
      fv_p1         <= 1'b0;
      o_pixel_valid <= 1'b0;
      o_pixel       <= '0;
      o_line_valid  <= 1'b0;
      o_frame_valid <= 1'b0;
    end else begin
      s1_vld        <= blk_done & last_row;
      s1_total      <= total;
      s1_m          <= m_cur;
      lv_p1         <= i_line_valid & i_frame_valid & active & last_row;
      fv_p1         <= i_frame_valid;
      o_pixel_valid <= s1_vld;
      if (s1_vld) o_pixel <= shifted[BPP-1:0];
      o_line_valid  <= lv_p1;
      o_frame_valid <= fv_p1;
    end
  end

endmodule
